shift_add_mult_8x8: RTL and testbench
=====================================

SHIFT_ADD_MULT_8X8 -- requirements
Module: shift_add_mult_8x8

Interface
REQ-001 The block SHALL have no parameters; operand widths are fixed at 8x8 bits with a 16-bit product.
REQ-002 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiply; sampled only on a rising edge of clk.
REQ-005 a  input  8  multiplicand (unsigned), captured when start is accepted.
REQ-006 b  input  8  multiplier (unsigned), captured when start is accepted.
REQ-007 product  output  16  registered result a*b, held until the next result is written.
REQ-008 busy  output  1  high while a multiply is in progress.
REQ-009 done  output  1  single-cycle pulse marking that product is valid and new.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, if start=1 at edge E, the block SHALL capture a into a 16-bit multiplicand register ({8'h00,a}), capture b into an 8-bit multiplier register, clear the 16-bit accumulator, clear the 3-bit step counter, and enter RUN.
REQ-012 In RUN at each edge, when multiplier[0]=1, the accumulator SHALL load the sum of accumulator and multiplicand; otherwise it SHALL hold.
REQ-013 The addition in REQ-012 SHALL be performed by one cla_16_bit instance with cin tied to 0.
REQ-014 At each RUN edge, the multiplicand SHALL shift left by 1, the multiplier SHALL shift right by 1, and the counter SHALL increment.
REQ-015 The block SHALL always execute exactly 8 RUN steps, with no early termination, so latency is fixed.
REQ-016 The RUN steps SHALL occur at edges E+1 through E+8.
REQ-017 At edge E+8, the block SHALL write product with the final accumulator value and enter DONE.
REQ-018 busy SHALL be 1 in RUN only, that is, from edge E to edge E+8.
REQ-019 done SHALL be 1 in DONE only, for exactly one cycle from edge E+8 to edge E+9.
REQ-020 From DONE with start=0, the FSM SHALL return to IDLE.
REQ-021 From DONE with start=1, a new operation SHALL be accepted, allowing back-to-back operation every 9 cycles.
REQ-022 start SHALL be ignored while in RUN; a, b and the operation in progress are unaffected.
REQ-023 The cla_16_bit cout SHALL be 0 on every RUN step, since the maximum product is 65025 < 2^16; cout is left unused.
REQ-024 product SHALL change only at the REQ-017 edge or on reset.

Reset
REQ-025 On rst_n=0, the block SHALL immediately and asynchronously clear all registers: FSM to IDLE, product=16'h0000, busy=0, done=0, accumulator, multiplicand, multiplier and counter to 0.
REQ-026 Reset asserted during RUN SHALL abort the operation, produce no done pulse, and leave product=0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Structure
REQ-028 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the step count constant (8) SHALL reside in the shared arithmetic package/header used by the adder blocks.
REQ-029 The block SHALL contain exactly one sub-module, cla_16_bit, used unmodified.
REQ-030 There SHALL be no other arithmetic operators on the datapath adder path.

Verification
REQ-031 a=13, b=11, start pulsed at edge E -> busy high for 8 cycles; at edge E+8 product=143 with a one-cycle done pulse.
REQ-032 a=255, b=255 -> product=65025 (16'hFE01) and cla cout=0 on all eight steps.
REQ-033 a=0, b=200, then a=200, b=0 -> product=0 both times with done timing identical to REQ-031.
REQ-034 a=7, b=9, then start held high with a=1, b=1 during RUN -> product=63; the second request is not taken until DONE, then product=1 nine cycles later.
REQ-035 Reset pulsed at step 4 of a=100, b=100 -> outputs are 0 immediately, no done pulse occurs, and a new start (a=3, b=5) gives product=15.
REQ-036 start held continuously with a=2, b=3 -> done pulses every 9 cycles and product=6 each time.

Source files
------------

// File: rtl/shift_add_mult_8x8_pkg.sv
// Shared arithmetic definitions for the shift-add multiplier and its adder.
//   state_t   : multiplier FSM state encoding (IDLE/RUN/DONE)
//   STEPS     : number of shift-add steps per multiply (one per multiplier bit)
//   CNT_W     : width of the step counter
//   CLA_W     : carry-lookahead adder width
//   CLA_GRP   : bits per lookahead group
package shift_add_mult_8x8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned STEPS   = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CLA_W   = 16;
  localparam int unsigned CLA_GRP = 4;

endpackage

// File: rtl/shift_add_mult_8x8_cla.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Group generate/propagate terms feed the inter-group carry chain.
// Ports:
//   a, b : 16-bit addends
//   cin  : carry in
//   sum  : 16-bit sum
//   cout : carry out of bit 15
module cla_16_bit
  import shift_add_mult_8x8_pkg::*;
(
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
  output logic [CLA_W-1:0] sum,
  output logic             cout
);

  localparam int unsigned NGRP = CLA_W / CLA_GRP;

  logic [CLA_W-1:0] w_g;
  logic [CLA_W-1:0] w_p;
  logic [CLA_W:0]   w_c;
  logic [NGRP-1:0]  w_gg;
  logic [NGRP-1:0]  w_gp;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Group G/P: a group generates if any bit generates and every bit above it propagates.
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int unsigned gi = 0; gi < NGRP; gi++) begin
      w_gp[gi] = &w_p[gi*CLA_GRP +: CLA_GRP];
      w_gg[gi] = w_g[gi*CLA_GRP + 3]
               | (w_p[gi*CLA_GRP + 3] & w_g[gi*CLA_GRP + 2])
               | (w_p[gi*CLA_GRP + 3] & w_p[gi*CLA_GRP + 2] & w_g[gi*CLA_GRP + 1])
               | (w_p[gi*CLA_GRP + 3] & w_p[gi*CLA_GRP + 2] & w_p[gi*CLA_GRP + 1]
                  & w_g[gi*CLA_GRP]);
    end
  end

  // Group-boundary carries come from lookahead; carries inside a group are
  // expanded from that group's incoming carry.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int unsigned gi = 0; gi < NGRP; gi++) begin
      for (int unsigned bi = 0; bi < CLA_GRP - 1; bi++) begin
        w_c[gi*CLA_GRP + bi + 1] = w_g[gi*CLA_GRP + bi]
                                 | (w_p[gi*CLA_GRP + bi] & w_c[gi*CLA_GRP + bi]);
      end
      w_c[(gi+1)*CLA_GRP] = w_gg[gi] | (w_gp[gi] & w_c[gi*CLA_GRP]);
    end
  end

  assign sum  = w_p ^ w_c[CLA_W-1:0];
  assign cout = w_c[CLA_W];

endmodule

// File: rtl/shift_add_mult_8x8.sv
// Sequential 8x8 unsigned shift-and-add multiplier, fixed 8-step latency.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : begin a multiply (accepted in IDLE or DONE, ignored in RUN)
//   a, b    : unsigned multiplicand / multiplier, captured on accept
//   product : registered 16-bit result, held until the next result
//   busy    : high while the multiply runs
//   done    : one-cycle pulse when product is freshly written
module shift_add_mult_8x8
  import shift_add_mult_8x8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t           r_state;
  logic [15:0]      r_mcand;
  logic [7:0]       r_mplier;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_product;
  logic             r_busy;
  logic             r_done;

  logic [15:0]      w_sum;
  logic             w_cout_unused;
  logic [15:0]      w_acc_next;

  // Product never exceeds 255*255, so the adder carry-out is always zero.
  cla_16_bit u_cla (
    .a    (r_acc),
    .b    (r_mcand),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout_unused)
  );

  assign w_acc_next = r_mplier[0] ? w_sum : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {8'h00, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_count  <= r_count + 1'b1;
          // Final step publishes the updated accumulator directly.
          if (r_count == LAST_STEP) begin
            r_product <= w_acc_next;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_add_mult_8x8.sv
module tb_shift_add_mult_8x8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [15:0] last_prod;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  shift_add_mult_8x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned multiplication.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  // Called #1 after a rising edge; start accepted at the next edge E,
  // result expected exactly at E+8.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input string tag);
    logic [15:0] exp;
    exp   = ref_mul(xa, xb);
    start = 1'b1;
    a     = xa;
    b     = xb;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    check({tag, "_busy_at_E"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_at_E"}, {31'd0, done}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      check({tag, "_cout"}, {31'd0, dut.w_cout_unused}, 32'd0);
      @(posedge clk); #1;
      if (k < 8) begin
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_run"}, {31'd0, done}, 32'd0);
        check({tag, "_prod_held"}, {16'd0, product}, {16'd0, last_prod});
      end else begin
        check({tag, "_done_E8"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_E8"}, {31'd0, busy}, 32'd0);
        check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
      end
    end
    last_prod = exp;
  endtask

  initial begin
    logic        saw_done;
    int unsigned gap;
    n_checks  = 0;
    n_errors  = 0;
    last_prod = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;

    tbl[0] = '{8'd13,  8'd11,  16'd143};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 16'd0};
    tbl[3] = '{8'd200, 8'd0,   16'd0};
    tbl[4] = '{8'd1,   8'd1,   16'd1};
    tbl[5] = '{8'd128, 8'd2,   16'd256};
    tbl[6] = '{8'd255, 8'd1,   16'd255};
    tbl[7] = '{8'd170, 8'd85,  16'd14450};

    #12;
    check("reset_product", {16'd0, product}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors: expected values are constants, cross-checked with the model.
    for (int i = 0; i < 8; i++) begin
      check("table_model", {16'd0, ref_mul(tbl[i].a, tbl[i].b)}, {16'd0, tbl[i].exp});
      run_op(tbl[i].a, tbl[i].b, "table");
    end
    @(posedge clk); #1;
    check("done_single_cycle", {31'd0, done}, 32'd0);
    check("idle_product_hold", {16'd0, product}, {16'd0, last_prod});

    // Start held during RUN is ignored; taken from DONE one edge later.
    start = 1'b1; a = 8'd7; b = 8'd9;
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) check("hold_busy", {31'd0, busy}, 32'd1);
    end
    check("hold_product_63", {16'd0, product}, 32'd63);
    check("hold_done_63", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_accept_from_done", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    check("hold_product_1", {16'd0, product}, 32'd1);
    check("hold_done_1", {31'd0, done}, 32'd1);
    last_prod = 16'd1;
    @(posedge clk); #1;

    // Reset during step 4 aborts the operation.
    start = 1'b1; a = 8'd100; b = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    #3 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_product_stays", {16'd0, product}, 32'd0);
    last_prod = '0;
    run_op(8'd3, 8'd5, "post_reset");

    // Start held continuously: a result every 9 cycles.
    @(posedge clk); #1;
    start = 1'b1; a = 8'd2; b = 8'd3;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    check("cont_first_done", {31'd0, done}, 32'd1);
    check("cont_first_product", {16'd0, product}, 32'd6);
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      saw_done = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        if (done && !saw_done) begin
          saw_done = 1'b1;
          gap = k;
        end
      end
      check("cont_gap", gap, 32'd9);
      check("cont_product", {16'd0, product}, 32'd6);
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    last_prod = 16'd6;

    // Randomized operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
